// File: rtl/imem_responder_pkg.sv
// Shared fetch-path constants and the packed response word carried from the
// instruction store back to decode.
package imem_responder_pkg;
  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] addr;
    logic              err;
  } rsp_t;

  localparam int RSP_W = $bits(rsp_t);
endpackage

// File: rtl/imem_responder_resp_fifo.sv
// Two-entry response FIFO, head always in r_ent0; push and pop may coincide.
// A push while full without a pop is ignored; the producer guarantees space.
module resp_fifo
  import imem_responder_pkg::*;
#(
  parameter rsp_t RST_VAL = '0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  rsp_t       i_dat,
  input  logic       i_pop,
  output rsp_t       o_head,
  output logic [1:0] o_occ
);
  rsp_t       r_ent0;
  rsp_t       r_ent1;
  logic [1:0] r_occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ent0 <= RST_VAL;
      r_ent1 <= RST_VAL;
      r_occ  <= 2'd0;
    end else begin
      case (r_occ)
        2'd0: begin
          if (i_push) begin
            r_ent0 <= i_dat;
            r_occ  <= 2'd1;
          end
        end
        2'd1: begin
          if (i_push && i_pop) begin
            r_ent0 <= i_dat;
          end else if (i_push) begin
            r_ent1 <= i_dat;
            r_occ  <= 2'd2;
          end else if (i_pop) begin
            r_occ  <= 2'd0;
          end
        end
        default: begin
          if (i_pop) begin
            r_ent0 <= r_ent1;
            if (i_push) r_ent1 <= i_dat;
            else        r_occ  <= 2'd1;
          end
        end
      endcase
    end
  end

  assign o_head = r_ent0;
  assign o_occ  = r_occ;
endmodule

// File: rtl/imem_responder.sv
// Instruction store with a one-deep read stage feeding a 2-entry response FIFO.
// req_ready counts stage + FIFO entries net of this cycle's pop, so nothing is ever dropped.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [INST_W-1:0] NOP_INST    = imem_responder_pkg::NOP_INST
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [ADDR_W-1:0]              req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [INST_W-1:0]              rsp_inst,
  output logic [ADDR_W-1:0]              rsp_addr,
  output logic                           rsp_err,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [INST_W-1:0]              ld_data
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [INST_W-1:0] r_mem [DEPTH_WORDS];
  logic              r_stg_valid;
  logic [ADDR_W-1:0] r_stg_addr;
  logic              r_stg_err;
  logic [INST_W-1:0] r_stg_inst;

  logic       w_accept;
  logic       w_pop;
  logic       w_req_err;
  logic [1:0] w_occ;
  logic [2:0] w_inflight;
  rsp_t       w_push_dat;
  rsp_t       w_head;

  assign w_req_err  = (req_addr[1:0] != 2'b00) ||
                      ({2'b00, req_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH_WORDS));
  assign w_pop      = rsp_valid && rsp_ready;
  assign w_inflight = {1'b0, w_occ} + {2'b00, r_stg_valid} - {2'b00, w_pop};
  assign req_ready  = !ld_en && (w_inflight < 3'd2);
  assign w_accept   = req_valid && req_ready;

  // Memory is deliberately not reset so contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (ld_en)    r_mem[ld_addr] <= ld_data;
    if (w_accept) r_stg_inst     <= r_mem[req_addr[AW+1:2]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stg_valid <= 1'b0;
      r_stg_addr  <= '0;
      r_stg_err   <= 1'b0;
    end else begin
      r_stg_valid <= w_accept;
      if (w_accept) begin
        r_stg_addr <= req_addr;
        r_stg_err  <= w_req_err;
      end
    end
  end

  assign w_push_dat = '{inst: (r_stg_err ? NOP_INST : r_stg_inst),
                        addr: r_stg_addr,
                        err:  r_stg_err};

  resp_fifo #(
    .RST_VAL('{inst: NOP_INST, addr: '0, err: 1'b0})
  ) u_resp_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_stg_valid),
    .i_dat  (w_push_dat),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_occ  (w_occ)
  );

  assign rsp_valid = (w_occ != 2'd0);
  assign rsp_inst  = w_head.inst;
  assign rsp_addr  = w_head.addr;
  assign rsp_err   = w_head.err;
endmodule

// File: tb/tb_imem_responder.sv
// Directed + random bench for imem_responder with a transaction-level reference model.
module tb_imem_responder;
  localparam int DEPTH = 1024;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_inst;
  logic [31:0] rsp_addr;
  logic        rsp_err;
  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  imem_responder #(.DEPTH_WORDS(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_inst(rsp_inst), .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
    int          cyc;
  } ent_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  ent_t        exp_q[$];
  ent_t        got_q[$];
  int          acc_q[$];
  logic [31:0] mdl_mem [DEPTH];
  logic [31:0] req_list[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: each accepted request becomes a queued response, visible
  // two cycles after its accept cycle, leaving in order.
  always @(negedge clk) begin
    ent_t e;
    logic m_vld;
    logic m_pop;
    cyc++;
    if (rst) begin
      exp_q.delete();
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    end else begin
      m_vld = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
      m_pop = m_vld && rsp_ready;
      check("rsp_valid", 32'(rsp_valid), 32'(m_vld));
      check("req_ready", 32'(req_ready),
            32'(!ld_en && ((exp_q.size() - int'(m_pop)) < 2)));
      if (m_vld) begin
        check("rsp_inst", rsp_inst, exp_q[0].inst);
        check("rsp_addr", rsp_addr, exp_q[0].addr);
        check("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
      end
      if (m_pop) begin
        e.inst = rsp_inst; e.addr = rsp_addr; e.err = rsp_err; e.cyc = cyc;
        got_q.push_back(e);
        void'(exp_q.pop_front());
      end
      if (req_valid && req_ready) begin
        e.addr = req_addr;
        e.err  = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH));
        e.inst = e.err ? NOP : mdl_mem[req_addr[11:2]];
        e.cyc  = cyc;
        exp_q.push_back(e);
        acc_q.push_back(cyc);
      end
      if (ld_en) mdl_mem[ld_addr] = ld_data;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = 10'(idx); ld_data = d;
    idle(1);
    ld_en = 1'b0;
  endtask

  task automatic drive_reqs(input int max_cyc);
    int n = 0;
    while (req_list.size() > 0 && n < max_cyc) begin
      req_valid = 1'b1; req_addr = req_list[0];
      @(negedge clk); n++;
      if (req_ready) void'(req_list.pop_front());
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic expect_got(input int idx, input logic [31:0] inst,
                            input logic [31:0] addr, input logic err);
    if (got_q.size() <= idx) begin
      check("got_present", 32'(got_q.size()), 32'(idx + 1));
    end else begin
      check("got_inst", got_q[idx].inst, inst);
      check("got_addr", got_q[idx].addr, addr);
      check("got_err", 32'(got_q[idx].err), 32'(err));
    end
  endtask

  initial begin
    int bg;
    int ba;
    int n_rand;
    int budget;
    int r;

    idle(2);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_inst", rsp_inst, NOP);
    check("reset_rsp_addr", rsp_addr, 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    idle(1);

    // Program and stream four back-to-back fetches.
    load(0, 32'h00500093); load(1, 32'h00a00113);
    load(2, 32'h002081b3); load(3, 32'h00000063);
    load(1023, 32'hdead_0ffc);
    rsp_ready = 1'b1;
    bg = got_q.size(); ba = acc_q.size();
    req_list = '{32'h0, 32'h4, 32'h8, 32'hC};
    drive_reqs(20);
    check("stream_left", 32'(req_list.size()), 32'd0);
    idle(5);
    expect_got(bg + 0, 32'h00500093, 32'h0, 1'b0);
    expect_got(bg + 1, 32'h00a00113, 32'h4, 1'b0);
    expect_got(bg + 2, 32'h002081b3, 32'h8, 1'b0);
    expect_got(bg + 3, 32'h00000063, 32'hC, 1'b0);
    if (got_q.size() >= bg + 4 && acc_q.size() >= ba + 4) begin
      check("first_latency", 32'(got_q[bg].cyc - acc_q[ba]), 32'd2);
      check("accept_rate", 32'(acc_q[ba + 3] - acc_q[ba]), 32'd3);
      check("rsp_rate", 32'(got_q[bg + 3].cyc - got_q[bg].cyc), 32'd3);
    end else begin
      check("stream_counts", 32'(got_q.size() - bg), 32'd4);
    end

    // Misaligned, out-of-range and last-word fetches.
    bg = got_q.size();
    req_list = '{32'h2, 32'h1000, 32'hFFC};
    drive_reqs(20);
    idle(5);
    expect_got(bg + 0, NOP, 32'h2, 1'b1);
    expect_got(bg + 1, NOP, 32'h1000, 1'b1);
    expect_got(bg + 2, 32'hdead_0ffc, 32'hFFC, 1'b0);

    // Backpressure: only two accepts while rsp_ready is low.
    rsp_ready = 1'b0;
    bg = got_q.size(); ba = acc_q.size();
    req_list = '{32'h0, 32'h4, 32'h8, 32'hC};
    drive_reqs(6);
    check("bp_accepts", 32'(acc_q.size() - ba), 32'd2);
    check("bp_req_ready", 32'(req_ready), 32'd0);
    check("bp_head_inst", rsp_inst, 32'h00500093);
    idle(3);
    check("bp_head_stable", rsp_addr, 32'h0);
    rsp_ready = 1'b1;
    drive_reqs(20);
    check("bp_left", 32'(req_list.size()), 32'd0);
    idle(5);
    expect_got(bg + 0, 32'h00500093, 32'h0, 1'b0);
    expect_got(bg + 1, 32'h00a00113, 32'h4, 1'b0);
    expect_got(bg + 2, 32'h002081b3, 32'h8, 1'b0);
    expect_got(bg + 3, 32'h00000063, 32'hC, 1'b0);

    // Load blocks a simultaneous fetch; the fetch then sees the new word.
    bg = got_q.size();
    ld_en = 1'b1; ld_addr = 10'd5; ld_data = 32'h1234_5678;
    req_valid = 1'b1; req_addr = 32'h14;
    #3;
    check("ld_blocks_req", 32'(req_ready), 32'd0);
    idle(1);
    ld_en = 1'b0;
    req_list = '{32'h14};
    drive_reqs(10);
    idle(5);
    expect_got(bg, 32'h1234_5678, 32'h14, 1'b0);

    // Asynchronous reset with two responses buffered.
    rsp_ready = 1'b0;
    req_list = '{32'h0, 32'h4};
    drive_reqs(10);
    idle(3);
    check("pre_rst_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(rsp_valid), 32'd0);
    idle(2);
    rst = 1'b0;
    rsp_ready = 1'b1;
    idle(1);
    bg = got_q.size();
    req_list = '{32'h0};
    drive_reqs(10);
    idle(5);
    expect_got(bg, 32'h00500093, 32'h0, 1'b0);

    // Random traffic with occasional loads into the low words.
    for (int i = 4; i < 16; i++) if (i != 5) load(i, 32'h1000_0000 + 32'(i));
    bg = got_q.size(); ba = acc_q.size();
    n_rand = 0; budget = 0;
    while (n_rand < 1000 && budget < 20000) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      ld_en     = ($urandom_range(0, 15) == 0);
      ld_addr   = 10'($urandom_range(0, 15));
      ld_data   = $urandom;
      req_valid = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 19);
      if (r < 16)       req_addr = 32'(r * 4);
      else if (r == 16) req_addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (r == 17) req_addr = 32'h1000 + 32'($urandom_range(0, 255) * 4);
      else if (r == 18) req_addr = 32'hFFC;
      else              req_addr = $urandom | 32'h8000_0000;
      @(negedge clk);
      if (req_valid && req_ready) n_rand++;
      @(posedge clk); #1;
      budget++;
    end
    req_valid = 1'b0; ld_en = 1'b0; rsp_ready = 1'b1;
    idle(6);
    check("rand_accepts", 32'(n_rand), 32'd1000);
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_count", 32'(got_q.size() - bg), 32'(acc_q.size() - ba));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
